// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and zigzag <-> raster index helpers.
// Pure combinational helpers; no state, no latency.
// No flow control; used by the decode-side reorder buffer and the encoder-side zigzag.
package jpeg_pkg;

  localparam int BLK_EDGE  = 8;
  localparam int BLK_COEFS = 64;

  // Zigzag scan position -> raster position (row*8 + col) within an 8x8 block.
  localparam logic [5:0] ZZ2RASTER [BLK_COEFS] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz2r(input logic [5:0] zz);
    return ZZ2RASTER[zz];
  endfunction

  function automatic logic [2:0] coef_row(input logic [5:0] raster);
    return raster[5:3];
  endfunction

  function automatic logic [2:0] coef_col(input logic [5:0] raster);
    return raster[2:0];
  endfunction

endpackage

// File: rtl/izz_bank.sv
// One 8x8 coefficient bank: single write port, 8-wide row read (plus column read with IZZ_TRANSPOSE_EN).
// Write lands on the clock edge; reads are combinational from storage.
// No flow control here; the parent decides when writes happen and which beat is read.
module izz_bank
  import jpeg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [5:0]      widx_i,
  input  logic [DW-1:0]   wdat_i,
  input  logic [2:0]      rsel_i,
  output logic [8*DW-1:0] row_o
`ifdef IZZ_TRANSPOSE_EN
  ,
  output logic [8*DW-1:0] col_o
`endif
);

  // Storage is intentionally not reset: a bank is only read once its full flag says it was rewritten.
  logic [DW-1:0] mem_q [BLK_COEFS];

  // Scatter one coefficient into its raster slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdat_i;
    end
  end

  // Row rsel_i, column 0 in the most significant lane.
  always_comb begin
    row_o = '0;
    for (int c = 0; c < BLK_EDGE; c++) begin
      row_o[8*DW-1-c*DW -: DW] = mem_q[{rsel_i, 3'(c)}];
    end
  end

`ifdef IZZ_TRANSPOSE_EN
  // Column rsel_i, row 0 in the most significant lane.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < BLK_EDGE; r++) begin
      col_o[8*DW-1-r*DW -: DW] = mem_q[{3'(r), rsel_i}];
    end
  end
`endif

endmodule

// File: rtl/izz_pingpong_buffer.sv
// Inverse-zigzag ping-pong buffer: zigzag coefficients in (1/cycle), raster rows of 8 out to the IDCT.
// First row is valid the cycle after the 64th coefficient of a block is accepted.
// in_ready drops only when both banks hold undrained blocks; out_data/out_row hold while out_ready is low.
// Optional build macro IZZ_TRANSPOSE_EN adds out_transpose for column-order output.
module izz_pingpong_buffer
  import jpeg_pkg::*;
#(
  parameter int DW  = 8,
  parameter int BLK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_data,
  output logic [2:0]      out_row,
  output logic            out_last
`ifdef IZZ_TRANSPOSE_EN
  ,
  input  logic            out_transpose
`endif
);

  if (BLK != BLK_EDGE) begin : g_blk_check
    $error("izz_pingpong_buffer: BLK must be 8");
  end

  logic [1:0] bank_full_q, bank_full_d;
  logic       wr_bank_q,   wr_bank_d;
  logic [5:0] wr_idx_q,    wr_idx_d;
  logic       rd_bank_q,   rd_bank_d;
  logic [2:0] rd_row_q,    rd_row_d;

  logic accept;
  logic xfer;
  logic [5:0] wr_raster;

  logic [8*DW-1:0] row_rd [2];
`ifdef IZZ_TRANSPOSE_EN
  logic [8*DW-1:0] col_rd [2];
  logic            tr_q, tr_d;
  logic            tr_now;
`endif

  // Handshake flags come from registered state only, never from in_valid/out_ready.
  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = bank_full_q[rd_bank_q];
  assign out_row   = rd_row_q;
  assign out_last  = out_valid && (rd_row_q == 3'd7);

  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign wr_raster = zz2r(wr_idx_q);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    izz_bank #(.DW(DW)) u_bank (
      .clk    (clk),
      .we_i   (accept && !flush && (wr_bank_q == 1'(b))),
      .widx_i (wr_raster),
      .wdat_i (in_data),
      .rsel_i (rd_row_q),
      .row_o  (row_rd[b])
`ifdef IZZ_TRANSPOSE_EN
      ,
      .col_o  (col_rd[b])
`endif
    );
  end

`ifdef IZZ_TRANSPOSE_EN
  // Beat 0 follows the live input; later beats use the mode captured when beat 0 transferred.
  assign tr_now   = (rd_row_q == 3'd0) ? out_transpose : tr_q;
  assign out_data = tr_now ? col_rd[rd_bank_q] : row_rd[rd_bank_q];
`else
  assign out_data = row_rd[rd_bank_q];
`endif

  // Next-state: write side fills wr_bank, read side drains rd_bank; flush overrides both.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
`ifdef IZZ_TRANSPOSE_EN
    tr_d        = tr_q;
`endif
    if (flush) begin
      bank_full_d = 2'b00;
      wr_bank_d   = 1'b0;
      wr_idx_d    = 6'd0;
      rd_bank_d   = 1'b0;
      rd_row_d    = 3'd0;
`ifdef IZZ_TRANSPOSE_EN
      tr_d        = 1'b0;
`endif
    end else begin
      if (accept) begin
        if (wr_idx_q == 6'(BLK_COEFS - 1)) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = !wr_bank_q;
          wr_idx_d               = 6'd0;
        end else begin
          wr_idx_d = wr_idx_q + 6'd1;
        end
      end
      // Set and clear never hit the same bank: a full rd_bank is never the bank being written.
      if (xfer) begin
`ifdef IZZ_TRANSPOSE_EN
        if (rd_row_q == 3'd0) begin
          tr_d = out_transpose;
        end
`endif
        if (rd_row_q == 3'd7) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
          rd_row_d               = 3'd0;
        end else begin
          rd_row_d = rd_row_q + 3'd1;
        end
      end
    end
  end

  // Control state registers; async reset discards any partial or pending block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= 6'd0;
      rd_bank_q   <= 1'b0;
      rd_row_q    <= 3'd0;
`ifdef IZZ_TRANSPOSE_EN
      tr_q        <= 1'b0;
`endif
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_row_q    <= rd_row_d;
`ifdef IZZ_TRANSPOSE_EN
      tr_q        <= tr_d;
`endif
    end
  end

endmodule

// File: tb/tb_izz_pingpong_buffer.sv
// Randomised bench for izz_pingpong_buffer against a block-queue reference model.
// Model: completed blocks wait in a queue (at most two), drained row by row.
// Build with IZZ_TRANSPOSE_EN defined to also exercise column-order output.
module tb_izz_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_row;
  logic        out_last;
  logic        out_transpose = 1'b0;

  izz_pingpong_buffer #(.DW(8), .BLK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
`ifdef IZZ_TRANSPOSE_EN
    .out_transpose (out_transpose),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [511:0] blk_t;
  blk_t        full_q[$];
  blk_t        part;
  int          part_n;
  int          row_n;
  bit          tr_lat;
  int          zz_r[64];
  int          naccept, nrows, nstall;
  logic [63:0] rows_seen[8];
  bit          acc_last;

  // Zigzag order from the diagonal walk: even diagonals climb (row decreasing), odd ones descend.
  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_r[k] = r*8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_r[k] = r*8 + (s - r); k++; end
      end
    end
  endtask

  function automatic logic [63:0] exp_beat(input blk_t b, input int r, input bit tr);
    logic [63:0] v = '0;
    for (int c = 0; c < 8; c++) begin
      int idx = tr ? (c*8 + r) : (r*8 + c);
      v[63-8*c -: 8] = b[idx*8 +: 8];
    end
    return v;
  endfunction

  task automatic model_reset();
    full_q.delete();
    part   = '0;
    part_n = 0;
    row_n  = 0;
    tr_lat = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model, move to the next negedge.
  task automatic cycle();
    bit er, ev, mode;
    logic [63:0] ed;
    #1;
    er = (full_q.size() < 2);
    ev = (full_q.size() > 0);
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    mode = 1'b0;
`ifdef IZZ_TRANSPOSE_EN
    mode = (row_n == 0) ? out_transpose : tr_lat;
`endif
    if (ev) begin
      ed = exp_beat(full_q[0], row_n, mode);
      chk("out_data", out_data, ed);
      chk("out_row", out_row, row_n);
      chk("out_last", out_last, row_n == 7);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    acc_last = 1'b0;
    if (flush) begin
      model_reset();
    end else begin
      if (in_valid && !er) nstall++;
      if (ev && out_ready) begin
        rows_seen[row_n] = out_data;
        nrows++;
        if (row_n == 0) tr_lat = mode;
        if (row_n == 7) begin
          void'(full_q.pop_front());
          row_n = 0;
        end else begin
          row_n++;
        end
      end
      if (in_valid && er) begin
        part[zz_r[part_n]*8 +: 8] = in_data;
        part_n++;
        naccept++;
        acc_last = 1'b1;
        if (part_n == 64) begin
          full_q.push_back(part);
          part   = '0;
          part_n = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer coefficients until n are accepted (bounded); idx_mode sends the zigzag index as data.
  task automatic feed(input int n, input bit idx_mode);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 4000) begin
      in_valid = 1'b1;
      in_data  = idx_mode ? 8'(part_n) : 8'($urandom);
      cycle();
      if (acc_last) got++;
      budget++;
    end
    in_valid = 1'b0;
    if (got < n) chk("feed_timeout", got, n);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [63:0] ROW0, ROW2, ROW7, COL0;
  int n0;

  initial begin
    ROW0 = {8'd0, 8'd1, 8'd5, 8'd6, 8'd14, 8'd15, 8'd27, 8'd28};
    ROW2 = {8'd3, 8'd8, 8'd12, 8'd17, 8'd25, 8'd30, 8'd41, 8'd43};
    ROW7 = {8'd35, 8'd36, 8'd48, 8'd49, 8'd57, 8'd58, 8'd62, 8'd63};
    COL0 = {8'd0, 8'd2, 8'd3, 8'd9, 8'd10, 8'd20, 8'd21, 8'd35};
    build_zigzag();
    model_reset();
    naccept = 0; nrows = 0; nstall = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_row", out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single block, data = zigzag index
    out_ready = 1'b1;
    n0 = nrows;
    feed(64, 1'b1);
    chk("lat_out_valid", out_valid, 1);
    idle(10);
    chk("sb_rows", nrows - n0, 8);
    chk("sb_row0", rows_seen[0], ROW0);
    chk("sb_row2", rows_seen[2], ROW2);
    chk("sb_row7", rows_seen[7], ROW7);

    // Backpressure: both banks fill, then drain
    out_ready = 1'b0;
    naccept = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 140; i++) begin
      in_data = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    chk("bp_accepts", naccept, 128);
    chk("bp_in_ready_lo", in_ready, 0);
    out_ready = 1'b1;
    n0 = nrows;
    for (int i = 0; i < 7; i++) cycle();
    chk("bp_rdy_before_row7", in_ready, 0);
    cycle();
    chk("bp_rdy_after_row7", in_ready, 1);
    idle(12);
    chk("bp_rows", nrows - n0, 16);

    // Streaming: four back-to-back blocks
    nstall = 0;
    n0 = nrows;
    feed(256, 1'b0);
    idle(12);
    chk("st_stalls", nstall, 0);
    chk("st_rows", nrows - n0, 32);

    // Flush mid-block
    feed(30, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAA;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    n0 = nrows;
    idle(10);
    chk("fl_no_rows", nrows - n0, 0);
    feed(64, 1'b1);
    idle(10);
    chk("fl_rows", nrows - n0, 8);
    chk("fl_row0", rows_seen[0], ROW0);
    chk("fl_row7", rows_seen[7], ROW7);

`ifdef IZZ_TRANSPOSE_EN
    // Column-order output
    out_transpose = 1'b1;
    out_ready = 1'b0;
    feed(64, 1'b1);
    #1;
    chk("tp_beat0", out_data, COL0);
    @(negedge clk);
    out_ready = 1'b1;
    idle(10);
    out_transpose = 1'b0;
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 1);
`ifdef IZZ_TRANSPOSE_EN
      out_transpose = $urandom_range(0, 1);
`endif
      cycle();
    end
    out_ready = 1'b1;
    idle(20);
    chk("rnd_drained", out_valid, 0);

    // Asynchronous reset with a pending block and a partial one
    out_ready = 1'b0;
    feed(70, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_last", out_last, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = nrows;
    idle(20);
    chk("arst_no_rows", nrows - n0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
